// File: rtl/fifo_packet_sync_if.sv
// fifo_packet_sync_if: writer/reader bundle for the packet FIFO.
// master drives writes and read requests, slave is the FIFO.
interface fifo_packet_sync_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int W_EL       = 20,
    parameter int W_DCNT     = 16
);
    logic                  wen;
    logic [W_EL-1:0]       wdata;
    logic                  wcommit;
    logic                  wdrop;
    logic                  full;
    logic                  afull;
    logic                  ren;
    logic [W_EL-1:0]       rdata;
    logic                  rvalid;
    logic                  empty;
    logic [ADDR_WIDTH:0]   rcount;
    logic [ADDR_WIDTH:0]   wcount;
    logic                  ovf;
    logic [W_DCNT-1:0]     drop_cnt;

    modport master (
        output wen, wdata, wcommit, wdrop, ren,
        input  full, afull, rdata, rvalid, empty,
        input  rcount, wcount, ovf, drop_cnt
    );

    modport slave (
        input  wen, wdata, wcommit, wdrop, ren,
        output full, afull, rdata, rvalid, empty,
        output rcount, wcount, ovf, drop_cnt
    );
endinterface

// File: rtl/fifo_packet_sync.sv
// fifo_packet_sync: packet-aware sync FIFO with commit/rollback frames.
// Define FIFO_PKT_DROP_CNT_EN to build the saturating drop counter.
module fifo_packet_sync #(
    parameter int ADDR_WIDTH   = 11,
    parameter int W_EL         = 20,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 16,
    parameter int W_DCNT       = 16
) (
    input logic               clk,
    input logic               reset,
    fifo_packet_sync_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [31:0]   AFULL_U = 32'(AFULL_THRESH);

    logic [PW-1:0]   wptr;
    logic [PW-1:0]   cptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wcount;
    logic [PW-1:0]   rcount;
    logic [PW-1:0]   wnext;
    logic            ovf;
    logic            full;
    logic            empty;
    logic            ovf_now;
    logic            drop_ev;
    logic            commit_ev;
    logic            wr_ok;
    logic            rd_ok;
    logic [W_EL-1:0] rdata;
    logic            rvalid;
    logic [W_EL-1:0] mem [DEPTH];

    // A frame that overflows on its commit cycle is dropped, not committed short.
    always_comb begin
        wcount    = wptr - rptr;
        rcount    = cptr - rptr;
        full      = (wcount == DEPTH_P);
        empty     = (rcount == '0);
        ovf_now   = ovf | (bus.wen & full);
        drop_ev   = bus.wdrop | (bus.wcommit & ovf_now);
        commit_ev = bus.wcommit & ~ovf_now & ~bus.wdrop;
        wr_ok     = bus.wen & ~full & ~ovf & ~drop_ev;
        rd_ok     = bus.ren & ~empty;
        wnext     = wptr + {{ADDR_WIDTH{1'b0}}, wr_ok};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr   <= '0;
            cptr   <= '0;
            rptr   <= '0;
            ovf    <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) begin
                rdata <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr  <= rptr + 1'b1;
            end
            if (drop_ev) begin
                wptr <= cptr;
                ovf  <= 1'b0;
            end else begin
                wptr <= wnext;
                ovf  <= ovf_now;
                if (commit_ev) cptr <= wnext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
    end

`ifdef FIFO_PKT_DROP_CNT_EN
    logic [W_DCNT-1:0] drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_ev && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + W_DCNT'(1);
        end
    end

    assign bus.drop_cnt = drop_cnt;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.wcount = wcount;
    assign bus.rcount = rcount;
    assign bus.full   = full;
    assign bus.afull  = 32'(wcount) >= AFULL_U;
    assign bus.empty  = empty;
    assign bus.ovf    = ovf;
    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;
endmodule

// File: tb/tb_fifo_packet_sync.sv
// tb_fifo_packet_sync: directed vectors for the packet FIFO (depth 16).
// drop_cnt expectations follow FIFO_PKT_DROP_CNT_EN.
module tb_fifo_packet_sync;
    localparam int AW = 4;
    localparam int WE = 16;
    localparam int WD = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    fifo_packet_sync_if #(.ADDR_WIDTH(AW), .W_EL(WE), .W_DCNT(WD)) bus ();

    fifo_packet_sync #(
        .ADDR_WIDTH  (AW),
        .W_EL        (WE),
        .AFULL_THRESH(12),
        .W_DCNT      (WD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen     = 1'b0;
        bus.wdata   = '0;
        bus.wcommit = 1'b0;
        bus.wdrop   = 1'b0;
        bus.ren     = 1'b0;
    endtask

    function automatic logic [31:0] dexp(input int n);
`ifdef FIFO_PKT_DROP_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_afull"}, bus.afull, 0);
        check({tag, "_rcount"}, bus.rcount, 0);
        check({tag, "_wcount"}, bus.wcount, 0);
        check({tag, "_ovf"}, bus.ovf, 0);
        check({tag, "_rvalid"}, bus.rvalid, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_dcnt"}, bus.drop_cnt, 0);
    endtask

    initial begin
        logic [WE-1:0] q[$];
        logic [WE-1:0] frm[$];
        logic [WE-1:0] v;
        int            got;

        n_chk  = 0;
        n_fail = 0;
        idle();
        reset = 1'b1;
        step();
        step();
        check_reset("rst");
        reset = 1'b0;

        // commit then read
        for (int i = 1; i <= 5; i++) begin
            bus.wen   = 1'b1;
            bus.wdata = WE'(i);
            step();
            check("t1_empty_wr", bus.empty, 1);
        end
        check("t1_wcount", bus.wcount, 5);
        idle();
        bus.wcommit = 1'b1;
        step();
        idle();
        check("t1_rcount", bus.rcount, 5);
        check("t1_empty_c", bus.empty, 0);
        bus.ren = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("t1_rvalid", bus.rvalid, 1);
            check("t1_rdata", bus.rdata, 32'(i));
        end
        idle();
        check("t1_empty_end", bus.empty, 1);
        step();
        check("t1_rvalid_off", bus.rvalid, 0);

        // drop
        for (int i = 1; i <= 3; i++) begin
            bus.wen     = 1'b1;
            bus.wdata   = WE'(16'hA0 + i);
            bus.wcommit = (i == 3);
            step();
        end
        for (int i = 1; i <= 4; i++) begin
            bus.wen     = 1'b1;
            bus.wdata   = WE'(16'hB0 + i);
            bus.wcommit = 1'b0;
            step();
        end
        idle();
        check("t2_wcount7", bus.wcount, 7);
        check("t2_rcount3", bus.rcount, 3);
        bus.wdrop = 1'b1;
        step();
        idle();
        check("t2_wcount3", bus.wcount, 3);
        check("t2_dcnt", bus.drop_cnt, dexp(1));
        bus.ren = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t2_rdata", bus.rdata, 32'(16'hA0 + i));
        end
        step();
        check("t2_rd_empty_rv", bus.rvalid, 0);
        check("t2_rd_empty_hold", bus.rdata, 32'h00A3);
        idle();

        // overflow
        for (int i = 1; i <= 20; i++) begin
            bus.wen   = 1'b1;
            bus.wdata = WE'(16'hC00 + i);
            step();
            if (i == 11) check("t3_afull11", bus.afull, 0);
            if (i == 12) check("t3_afull12", bus.afull, 1);
            if (i == 15) check("t3_full15", bus.full, 0);
            if (i == 16) begin
                check("t3_full16", bus.full, 1);
                check("t3_ovf16", bus.ovf, 0);
            end
            if (i == 17) check("t3_ovf17", bus.ovf, 1);
        end
        check("t3_wcount", bus.wcount, 16);
        check("t3_empty", bus.empty, 1);
        idle();
        bus.wcommit = 1'b1;
        step();
        idle();
        check("t3_wcount0", bus.wcount, 0);
        check("t3_empty_c", bus.empty, 1);
        check("t3_ovf_clr", bus.ovf, 0);
        check("t3_dcnt", bus.drop_cnt, dexp(2));

        // commit and drop together
        for (int i = 1; i <= 2; i++) begin
            bus.wen   = 1'b1;
            bus.wdata = WE'(16'hD0 + i);
            step();
        end
        idle();
        bus.wcommit = 1'b1;
        bus.wdrop   = 1'b1;
        step();
        idle();
        check("t5_wcount", bus.wcount, 0);
        check("t5_empty", bus.empty, 1);
        check("t5_dcnt", bus.drop_cnt, dexp(3));

        // streaming frames with concurrent drain, 3 pointer passes
        got = 0;
        for (int f = 0; f < 24; f++) begin
            for (int j = 0; j < 4; j++) begin
                v           = WE'(16'h100 + f * 4 + j);
                bus.wen     = 1'b1;
                bus.wdata   = v;
                bus.wcommit = (j == 3);
                bus.ren     = 1'b1;
                frm.push_back(v);
                step();
                if (j == 3) begin
                    while (frm.size() > 0) q.push_back(frm.pop_front());
                end
                if (bus.rvalid) begin
                    got++;
                    if (q.size() == 0) check("t4_extra", bus.rdata, 32'hFFFF_FFFF);
                    else check("t4_rdata", bus.rdata, 32'(q.pop_front()));
                end
            end
        end
        idle();
        bus.ren = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.rvalid) begin
                got++;
                if (q.size() == 0) check("t4_extra", bus.rdata, 32'hFFFF_FFFF);
                else check("t4_rdata", bus.rdata, 32'(q.pop_front()));
            end
        end
        idle();
        check("t4_count", 32'(got), 96);
        check("t4_left", 32'(q.size()), 0);
        check("t4_empty", bus.empty, 1);
        check("t4_wcount", bus.wcount, 0);

        // async reset mid-frame
        for (int i = 1; i <= 2; i++) begin
            bus.wen     = 1'b1;
            bus.wdata   = WE'(16'hE0 + i);
            bus.wcommit = (i == 2);
            step();
        end
        idle();
        bus.wen   = 1'b1;
        bus.wdata = WE'(16'hF1);
        bus.ren   = 1'b1;
        step();
        idle();
        check("t6_pre_rvalid", bus.rvalid, 1);
        check("t6_pre_rdata", bus.rdata, 32'h00E1);
        check("t6_pre_wcount", bus.wcount, 2);
        #2;
        reset = 1'b1;
        #1;
        check_reset("t6");
        reset = 1'b0;
        step();
        check("t6_post_empty", bus.empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
